uart_tx: RTL
============

# uart_tx

Serial transmitter for the APB UART. Consumes the transmit byte, frame configuration and start request held in the register block, and serialises one asynchronous frame on `tx`: start bit, 5–8 data bits LSB first, optional parity, then 1 or 2 stop bits. It returns `tx_done` to the status register and pulses `start_tx_re_cfg` so the register block clears its start control bit.

## Interface
- `CLK_DIV`, default 434: clock cycles per serial bit; minimum 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send; only the low N bits are used.
- `data_bit_num`  in  2  data length: 00=5, 01=6, 10=7, 11=8 bits.
- `stop_bit_num`  in  1  0 = one stop bit, 1 = two stop bits.
- `parity_en`  in  1  1 = insert a parity bit after the data bits.
- `parity_type`  in  1  0 = even parity, 1 = odd parity.
- `start_tx`  in  1  level request; sampled only in IDLE.
- `tx`  out  1  serial line; idle high; driven from a register.
- `tx_done`  out  1  1 while idle or complete, 0 while a frame is in progress.
- `start_tx_re_cfg`  out  1  one-cycle pulse when a frame is accepted.

## Operation
- Reset values: `tx`=1, `tx_done`=1, `start_tx_re_cfg`=0, FSM in IDLE, all counters 0.
- FSM states: IDLE → START → DATA → (PARITY if `parity_en`) → STOP → IDLE.
- **Frame acceptance:** in IDLE with `start_tx`=1, the block latches `tx_data`, N, `stop_bit_num`, `parity_en` and `parity_type`. It then:
  - moves to START,
  - clears `tx_done`,
  - pulses `start_tx_re_cfg` for exactly one cycle.
- **Config stability:** input changes after acceptance have no effect on the frame in progress.
- **Baud counter:** counts 0..CLK_DIV-1 within each bit and wraps to 0 at each bit boundary.
- **Data bits:** a bit counter selects the data bit, LSB first, and counts 0..N-1.
- **Stop bits:** the stop counter counts 0..S-1, where S = 1 or 2.
- **Parity bit:**
  - Even (`parity_type`=0): p = XOR of the N latched data bits.
  - Odd (`parity_type`=1): p = inverted XOR of the N latched data bits.
  - Bits above N never contribute.
- **Line level per state:** START drives 0; DATA drives the current data bit; PARITY drives p; STOP drives 1.
- **End of frame:** at the end of the last stop bit the FSM enters IDLE and sets `tx_done`=1 on the same edge.
- **Back-to-back frames:** if `start_tx` is still 1 in IDLE, the next frame is accepted on the following edge. This gives exactly one idle cycle (`tx`=1, `tx_done`=1) between frames.
- **Reset mid-frame:** asserting `reset_n` low immediately forces the reset values. The partial frame is abandoned, with no completion and no pulse.

## Timing
- **Acceptance latency:** `start_tx` sampled high at edge E gives, from edge E onward, `tx`=0, `tx_done`=0 and `start_tx_re_cfg`=1. The pulse clears at edge E+1.
- **Bit length:** each bit occupies exactly CLK_DIV cycles.
- **Frame length:** (1 + N + P + S)·CLK_DIV cycles, where P = `parity_en`. `tx_done` rises at edge E + that count.
- **Output quality:** `tx` and `tx_done` are glitch-free register outputs.

## Structure
- Package `uart_pkg`, shared with the receiver and register block, holds:
  - state enum `tx_state_e` {IDLE, START, DATA, PARITY, STOP},
  - data-length encoding constants,
  - `STOP_1` / `STOP_2` constants,
  - `PARITY_EVEN` / `PARITY_ODD` constants.
- Sub-module `uart_baud_cnt`:
  - parameter CLK_DIV, input `clear`, output `bit_end`;
  - `bit_end` is high on cycle CLK_DIV-1 of each bit;
  - the receiver reuses this block.

## Test plan
All scenarios use CLK_DIV=4.

1. **Reset:** hold `reset_n`=0 → `tx`=1, `tx_done`=1, `start_tx_re_cfg`=0. Release with `start_tx`=0 → outputs unchanged for 20 cycles.
2. **8N1, 0xA5:** set `data_bit_num`=11, `parity_en`=0, `stop_bit_num`=0, pulse `start_tx` → `start_tx_re_cfg` high for 1 cycle; `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; `tx_done` low for exactly 40 cycles.
3. **7E2, 0x35:** set `data_bit_num`=10, `parity_en`=1, `parity_type`=0, `stop_bit_num`=1 → data 1,0,1,0,1,1,0, parity 0, two stop bits; frame lasts 44 cycles.
4. **5O1, 0xFF:** set `data_bit_num`=00, `parity_en`=1, `parity_type`=1 → data 1,1,1,1,1, parity 0; frame lasts 32 cycles. Upper bits are ignored.
5. **Back-to-back and config stability:** hold `start_tx`=1 and change `tx_data` from 0x0F to 0xF0 mid-frame → the first frame carries 0x0F; exactly one idle cycle follows; the second frame carries 0xF0; `start_tx_re_cfg` pulses once per frame.
6. **Reset mid-frame:** assert `reset_n`=0 during data bit 3 → `tx`=1 and `tx_done`=1 with no clock edge. After release, an 8N1 0x5A frame is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame-format encodings and parity helper.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Parity over the low 5..8 data bits; odd parity is the inverted XOR.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] len,
                                       input logic ptype);
    logic p;
    p = (ptype == PARITY_ODD);
    for (int i = 0; i < 8; i++) begin
      if (i < int'(len) + 5) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: flags the last clock cycle of each serial bit while not cleared.
`timescale 1ns/1ps
module uart_baud_cnt #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end = !clear && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises start, 5-8 data bits LSB first, optional parity and 1-2 stop bits.
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       start_tx,
  output logic       tx,
  output logic       tx_done,
  output logic       start_tx_re_cfg
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [1:0] len_q, len_d;
  logic       stop_num_q, stop_num_d;
  logic       par_en_q, par_en_d;
  logic       par_q, par_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       re_q, re_d;

  logic       bit_end;
  logic [2:0] last_bit;
  logic [2:0] next_bit;

  uart_baud_cnt #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == IDLE),
    .bit_end(bit_end)
  );

  assign last_bit = 3'd4 + {1'b0, len_q};
  assign next_bit = bit_cnt_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    len_d      = len_q;
    stop_num_d = stop_num_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = done_q;
    re_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        done_d = 1'b1;
        if (start_tx) begin
          // Snapshot the whole frame config so later register writes cannot disturb it.
          data_d     = tx_data;
          len_d      = data_bit_num;
          stop_num_d = stop_bit_num;
          par_en_d   = parity_en;
          par_d      = calc_parity(tx_data, data_bit_num, parity_type);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = START;
          tx_d       = 1'b0;
          done_d     = 1'b0;
          re_d       = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = data_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == last_bit) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_cnt_d = next_bit;
            tx_d      = data_q[next_bit];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_cnt_q == stop_num_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      len_q      <= '0;
      stop_num_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b1;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      len_q      <= len_d;
      stop_num_q <= stop_num_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      re_q       <= re_d;
    end
  end

  assign tx              = tx_q;
  assign tx_done         = done_q;
  assign start_tx_re_cfg = re_q;

endmodule
